// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - MIPS instruction fetch unit: PC, imem req/ack fetch, ins valid/ready, next-PC select
// Optional IFU_DELAY_SLOT_EN: taken branch/jump redirects after one delay-slot instruction.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] pc,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero
);

  typedef enum logic {FETCH = 1'b0, VALID = 1'b1} stateT;

  stateT       state;
  logic [31:0] pc4;
  logic [31:0] bTarget;
  logic [31:0] jTarget;
  logic [31:0] target;
  logic [31:0] nextPc;
  logic        taken;
  logic        consume;

  always_comb begin
    pc4     = pc + 32'd4;
    bTarget = pc4 + {{14{ins[15]}}, ins[15:0], 2'b00};
    jTarget = {pc4[31:28], ins[25:0], 2'b00};
    taken   = jump | (branch & zero);
    target  = jump ? jTarget : bTarget;
  end

  assign consume   = (state == VALID) && ins_ready;
  // Gated with rst_n so the request drops the instant reset asserts, mid-fetch included.
  assign imem_req  = (state == FETCH) && rst_n;
  assign imem_addr = pc;
  assign ins_valid = (state == VALID);

`ifdef IFU_DELAY_SLOT_EN
  logic        pend;
  logic [31:0] pendTarget;

  // While a redirect is pending, the consumed instruction is the delay slot; its own branch/jump is dropped.
  assign nextPc = pend ? pendTarget : pc4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= 1'b0;
      pendTarget <= '0;
    end else if (consume) begin
      if (pend) begin
        pend <= 1'b0;
      end else if (taken) begin
        pend       <= 1'b1;
        pendTarget <= target;
      end
    end
  end
`else
  assign nextPc = taken ? target : pc4;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      pc    <= RESET_PC;
      ins   <= '0;
    end else if (state == FETCH) begin
      if (imem_ack) begin
        ins   <= imem_rdata;
        state <= VALID;
      end
    end else begin
      if (consume) begin
        pc    <= nextPc;
        state <= FETCH;
      end
    end
  end

endmodule
